// File: rtl/mix_loader_if.sv
// MIX loader bus bundle.
// Byte-stream receive side plus core memory write port.
interface mix_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [30:0] mem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/mix_loader.sv
// MIX core image loader.
// Length, words, XOR checksum; holds core in reset until loaded.
module mix_loader #(
  parameter int MEM_WORDS = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  mix_loader_if.master  bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAXN = 17'(MEM_WORDS);

  state_t      state, state_nx;
  logic        rdy, xfer, can_start, len_ok;
  logic [15:0] n16;
  logic [7:0]  len_lo, csum;
  logic [11:0] idx, last;
  logic [1:0]  bi;
  logic [23:0] asm_w;
  logic        we_q;
  logic [11:0] addr_q;
  logic [30:0] wdata_q;

  assign rdy = (state == LEN_LO) || (state == LEN_HI)
            || (state == DATA)   || (state == CHECK);
  assign busy = rdy;
  assign xfer = bus.rx_valid & rdy;
  assign can_start = (state == IDLE) || (state == DONE)
                  || (state == ERR);
  assign n16 = {bus.rx_data, len_lo};
  assign len_ok = (n16 != 16'd0) && ({1'b0, n16} <= MAXN);

  assign bus.rx_ready  = rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and status decode.
  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    err       = 1'b0;
    cpu_reset = 1'b1;
    unique case (state)
      IDLE: if (start) state_nx = LEN_LO;
      LEN_LO: if (xfer) state_nx = LEN_HI;
      LEN_HI: if (xfer) state_nx = len_ok ? DATA : ERR;
      DATA: begin
        if (xfer && bi == 2'd3) begin
          if (bus.rx_data[7])   state_nx = ERR;
          else if (idx == last) state_nx = CHECK;
        end
      end
      CHECK: begin
        if (xfer)
          state_nx = (bus.rx_data == csum) ? DONE : ERR;
      end
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_nx = LEN_LO;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nx = LEN_LO;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word assembly, checksum and write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo  <= '0;
      last    <= '0;
      idx     <= '0;
      bi      <= '0;
      csum    <= '0;
      asm_w   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (start && can_start) begin
        idx   <= '0;
        bi    <= '0;
        csum  <= '0;
        asm_w <= '0;
      end
      if (xfer && state == LEN_LO)
        len_lo <= bus.rx_data;
      if (xfer && state == LEN_HI)
        last <= n16[11:0] - 12'd1;
      if (xfer && state == DATA) begin
        csum <= csum ^ bus.rx_data;
        bi   <= bi + 2'd1;
        unique case (bi)
          2'd0: asm_w[7:0]   <= bus.rx_data;
          2'd1: asm_w[15:8]  <= bus.rx_data;
          2'd2: asm_w[23:16] <= bus.rx_data;
          2'd3: begin
            if (!bus.rx_data[7]) begin
              we_q    <= 1'b1;
              addr_q  <= idx;
              wdata_q <= {bus.rx_data[6:0], asm_w};
              if (idx != last) idx <= idx + 12'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mix_loader.sv
// Scoreboard bench for mix_loader.
// Random streams vs. a queue-based stream model.
module tb_mix_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, busy, done, err;

  mix_loader_if bus();

  mix_loader #(.MEM_WORDS(4096)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .cpu_reset(cpu_reset),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [42:0] exp_q[$];
  logic [31:0] words[$];
  logic [42:0] mon_e;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h",
                  name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("stray_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(mon_e[42:31]));
        chk("wr_data", 32'(bus.mem_wdata), 32'(mon_e[30:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    int g;
    g = $urandom_range(0, gapmax);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start(input logic with_byte);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (with_byte) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hFF;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  // Model: builds the byte stream, expected writes and final status.
  task automatic run_load(input logic [15:0] n,
                          input logic [7:0] adj,
                          input int gapmax,
                          input logic with_byte);
    logic [7:0] stream[$];
    logic [7:0] cs;
    logic [7:0] by;
    logic [31:0] w;
    logic exp_done;
    logic stop;
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    cs = 8'd0;
    exp_done = 1'b0;
    stop = (n == 16'd0) || (n > 16'd4096);
    for (int i = 0; i < int'(n) && !stop; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        by = w[8*j +: 8];
        stream.push_back(by);
        cs = cs ^ by;
      end
      if (w[31]) stop = 1'b1;
      else exp_q.push_back({12'(i), w[30:0]});
    end
    if (!stop) begin
      stream.push_back(cs ^ adj);
      exp_done = (adj == 8'd0);
    end
    pulse_start(with_byte);
    foreach (stream[k]) send_byte(stream[k], gapmax);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(!exp_done));
    chk("cpu_reset", 32'(cpu_reset), 32'(!exp_done));
    chk("busy_end", 32'(busy), 32'd0);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    #12;
    chk_reset_outs("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_ready", 32'(bus.rx_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;

    words = '{32'h0000_0005, 32'h4000_0001};
    run_load(16'd2, 8'd0, 0, 1'b0);

    words.delete();
    run_load(16'h0000, 8'd0, 0, 1'b0);
    run_load(16'h1001, 8'd0, 1, 1'b0);

    words = '{32'h8000_0000};
    run_load(16'd1, 8'd0, 0, 1'b0);

    words = '{32'h1234_5678};
    run_load(16'd1, 8'd1, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      words.delete();
      for (int i = 0; i < 8; i++) begin
        w = $urandom;
        w[31] = ($urandom_range(0, 9) == 0);
        words.push_back(w);
      end
      run_load(16'($urandom_range(1, 8)),
               ($urandom_range(0, 3) == 0) ?
                 8'($urandom_range(1, 255)) : 8'd0,
               2, (t % 2) == 0);
    end

    words.delete();
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      w[31] = 1'b0;
      words.push_back(w);
    end
    run_load(16'd4096, 8'd0, 1, 1'b1);

    pulse_start(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    words = '{32'h0102_0304};
    run_load(16'd1, 8'd0, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
